// File: rtl/prbs_lock_monitor.sv
// Lock monitor for the PRBS pattern detector's detection strobe.
// Learns the detection period, confirms it over LOCK_COUNT on-period hits,
// declares lock, counts misses and out-of-phase hits while locked, and drops
// lock after MISS_LIMIT consecutive misses.
//
// Ports:
//   CLK               clock, rising edge
//   RSTn              asynchronous active-low reset
//   enable            run; low forces IDLE and clears counters (period holds)
//   pattern_detected  one-cycle detection strobe
//   period            measured detection interval in cycles
//   locked            lock status
//   lock_lost         one-cycle pulse when lock drops through misses
//   det_count         detections seen while enabled (saturating)
//   miss_count        misses counted while locked (saturating)
//   state             0 IDLE, 1 SEARCH, 2 MEASURE, 3 VERIFY, 4 LOCKED
module prbs_lock_monitor #(
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MISS_LIMIT = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             enable,
    input  logic             pattern_detected,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             lock_lost,
    output logic [15:0]      det_count,
    output logic [15:0]      miss_count,
    output logic [2:0]       state
);

    localparam int unsigned RUN_W  = 4;
    localparam int unsigned STAT_W = 16;

    localparam logic [CNT_W-1:0]  S_MAX     = '1;
    localparam logic [STAT_W-1:0] STAT_MAX  = '1;
    localparam logic [RUN_W-1:0]  LOCK_TGT  = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0]  MISS_TGT  = RUN_W'(MISS_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_LOCKED  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  s_q, s_d;
    logic [RUN_W-1:0]  good_q, good_d;
    logic [RUN_W-1:0]  miss_run_q, miss_run_d;
    logic [CNT_W-1:0]  period_d;
    logic              locked_d;
    logic              lock_lost_d;
    logic [STAT_W-1:0] det_count_d;
    logic [STAT_W-1:0] miss_count_d;

    // Interval counter sits on an expected point when it equals the period
    logic on_point_c;
    logic miss_c;

    assign on_point_c = (s_q == period);
    // In LOCKED a miss is a silent expected point or a strobe anywhere else
    assign miss_c     = on_point_c ? !pattern_detected : pattern_detected;

    assign state = state_q;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            good_q     <= '0;
            miss_run_q <= '0;
            period     <= '0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            det_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            good_q     <= good_d;
            miss_run_q <= miss_run_d;
            period     <= period_d;
            locked     <= locked_d;
            lock_lost  <= lock_lost_d;
            det_count  <= det_count_d;
            miss_count <= miss_count_d;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_d      = state_q;
        s_d          = (s_q == S_MAX) ? s_q : s_q + CNT_W'(1);
        good_d       = good_q;
        miss_run_d   = miss_run_q;
        period_d     = period;
        locked_d     = locked;
        lock_lost_d  = 1'b0;
        det_count_d  = det_count;
        miss_count_d = miss_count;

        if (!enable) begin
            state_d      = ST_IDLE;
            s_d          = '0;
            good_d       = '0;
            miss_run_d   = '0;
            locked_d     = 1'b0;
            det_count_d  = '0;
            miss_count_d = '0;
        end else begin
            if (pattern_detected && (state_q != ST_IDLE) && (det_count != STAT_MAX)) begin
                det_count_d = det_count + STAT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                end

                ST_SEARCH: begin
                    if (pattern_detected) begin
                        s_d     = CNT_W'(1);
                        state_d = ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    if (pattern_detected) begin
                        period_d = s_q;
                        good_d   = RUN_W'(1);
                        s_d      = CNT_W'(1);
                        if (LOCK_TGT == RUN_W'(1)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            good_d   = '0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else if (s_q == S_MAX) begin
                        state_d = ST_SEARCH;
                    end
                end

                ST_VERIFY: begin
                    if (pattern_detected) begin
                        s_d = CNT_W'(1);
                        if (on_point_c) begin
                            if (good_q + RUN_W'(1) == LOCK_TGT) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                                good_d   = '0;
                            end else begin
                                good_d = good_q + RUN_W'(1);
                            end
                        end else begin
                            // Early strobe: the shorter interval becomes the new candidate
                            period_d = s_q;
                            good_d   = RUN_W'(1);
                        end
                    end else if (on_point_c) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                    end
                end

                ST_LOCKED: begin
                    // Re-anchor at every expected point so phase survives misses
                    if (on_point_c) begin
                        s_d = CNT_W'(1);
                    end
                    if (on_point_c && pattern_detected) begin
                        miss_run_d = '0;
                    end
                    if (miss_c) begin
                        if (miss_count != STAT_MAX) begin
                            miss_count_d = miss_count + STAT_W'(1);
                        end
                        if (miss_run_q + RUN_W'(1) == MISS_TGT) begin
                            miss_run_d  = '0;
                            lock_lost_d = 1'b1;
                            locked_d    = 1'b0;
                            state_d     = ST_SEARCH;
                        end else begin
                            miss_run_d = miss_run_q + RUN_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_lock_monitor.sv
// Self-checking bench for prbs_lock_monitor: directed vector table, a
// short-counter timeout sequence, randomized strobes against a timestamp-based
// reference model, and an asynchronous reset check.
module tb_prbs_lock_monitor;

    localparam int LOCK_COUNT = 3;
    localparam int MISS_LIMIT = 2;
    localparam int SMAX_A     = 65535;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        en_a, det_a, en_b, det_b;
    logic [15:0] period_a;
    logic        locked_a, lost_a;
    logic [15:0] dc_a, mc_a;
    logic [2:0]  state_a;
    logic [3:0]  period_b;
    logic        locked_b, lost_b;
    logic [15:0] dc_b, mc_b;
    logic [2:0]  state_b;

    always #5 CLK = ~CLK;

    prbs_lock_monitor #(.LOCK_COUNT(3), .MISS_LIMIT(2), .CNT_W(16)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .enable(en_a), .pattern_detected(det_a),
        .period(period_a), .locked(locked_a), .lock_lost(lost_a),
        .det_count(dc_a), .miss_count(mc_a), .state(state_a)
    );

    prbs_lock_monitor #(.LOCK_COUNT(3), .MISS_LIMIT(2), .CNT_W(4)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .enable(en_b), .pattern_detected(det_b),
        .period(period_b), .locked(locked_b), .lock_lost(lost_b),
        .det_count(dc_b), .miss_count(mc_b), .state(state_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_a(input string tag, input int st, input int lk, input int lost,
                           input longint per, input int dc, input int mc);
        check({tag, ".state"},      longint'(state_a),  longint'(st));
        check({tag, ".locked"},     longint'(locked_a), longint'(lk));
        check({tag, ".lock_lost"},  longint'(lost_a),   longint'(lost));
        check({tag, ".period"},     longint'(period_a), per);
        check({tag, ".det_count"},  longint'(dc_a),     longint'(dc));
        check({tag, ".miss_count"}, longint'(mc_a),     longint'(mc));
    endtask

    // Inputs change at the falling edge; outputs are sampled one falling edge later
    task automatic tick_a(input logic e, input logic d);
        en_a  = e;
        det_a = d;
        @(negedge CLK);
    endtask

    task automatic tick_b(input logic e, input logic d);
        en_b  = e;
        det_b = d;
        @(negedge CLK);
    endtask

    // Reference model: s is derived from the timestamp at which it last read 0
    int     m_state, m_period, m_locked, m_lost, m_det, m_miss, m_good, m_mrun;
    longint cyc, m_zero;

    task automatic model_reset();
        m_state = 0; m_period = 0; m_locked = 0; m_lost = 0;
        m_det = 0; m_miss = 0; m_good = 0; m_mrun = 0;
        cyc = 0; m_zero = 0;
    endtask

    task automatic model_edge(input bit e, input bit d);
        longint s;
        bit     on_time, missed;
        s = cyc - m_zero;
        if (s > SMAX_A) s = SMAX_A;
        m_lost = 0;
        if (!e) begin
            m_state = 0; m_locked = 0; m_det = 0; m_miss = 0;
            m_good = 0; m_mrun = 0; m_zero = cyc + 1;
        end else begin
            if (d && m_state != 0 && m_det < 65535) m_det++;
            case (m_state)
                0: m_state = 1;
                1: if (d) begin m_zero = cyc; m_state = 2; end
                2: begin
                    if (d) begin
                        m_period = int'(s); m_good = 1; m_zero = cyc;
                        if (LOCK_COUNT == 1) begin m_state = 4; m_locked = 1; end
                        else m_state = 3;
                    end else if (s == SMAX_A) m_state = 1;
                end
                3: begin
                    if (d) begin
                        m_zero = cyc;
                        if (s == m_period) begin
                            m_good++;
                            if (m_good >= LOCK_COUNT) begin m_state = 4; m_locked = 1; m_good = 0; end
                        end else begin
                            m_period = int'(s); m_good = 1;
                        end
                    end else if (s == m_period) begin
                        m_state = 1; m_good = 0;
                    end
                end
                default: begin
                    on_time = (s == m_period);
                    missed  = on_time ? !d : d;
                    if (on_time) m_zero = cyc;
                    if (on_time && d) m_mrun = 0;
                    if (missed) begin
                        if (m_miss < 65535) m_miss++;
                        m_mrun++;
                        if (m_mrun >= MISS_LIMIT) begin
                            m_lost = 1; m_locked = 0; m_state = 1; m_mrun = 0;
                        end
                    end
                end
            endcase
        end
        cyc++;
    endtask

    task automatic rstep(input bit e, input bit d);
        model_edge(e, d);
        tick_a(e, d);
        check_a("rnd", m_state, m_locked, m_lost, longint'(m_period), m_det, m_miss);
    endtask

    typedef struct {
        int en; int idle; int strobe;
        int st; int lk; int lost; int per; int dc; int mc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // en, idle ticks, strobe, then expected state/locked/lost/period/det/miss
        vecs.push_back('{1, 1, 0,  1, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 3, 1,  2, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 7, 1,  3, 0, 0, 8, 2, 0});
        vecs.push_back('{1, 7, 1,  3, 0, 0, 8, 3, 0});
        vecs.push_back('{1, 7, 1,  4, 1, 0, 8, 4, 0});
        vecs.push_back('{1, 7, 1,  4, 1, 0, 8, 5, 0});
        vecs.push_back('{1, 15, 1, 4, 1, 0, 8, 6, 1});
        vecs.push_back('{1, 15, 1, 4, 1, 0, 8, 7, 2});
        vecs.push_back('{1, 7, 1,  4, 1, 0, 8, 8, 2});
        vecs.push_back('{1, 2, 1,  4, 1, 0, 8, 9, 3});
        vecs.push_back('{1, 4, 1,  4, 1, 0, 8, 10, 3});
        vecs.push_back('{1, 16, 0, 1, 0, 1, 8, 10, 5});
        vecs.push_back('{1, 1, 0,  1, 0, 0, 8, 10, 5});
        vecs.push_back('{1, 2, 1,  2, 0, 0, 8, 11, 5});
        vecs.push_back('{1, 7, 1,  3, 0, 0, 8, 12, 5});
        vecs.push_back('{1, 4, 1,  3, 0, 0, 5, 13, 5});
        vecs.push_back('{1, 4, 1,  3, 0, 0, 5, 14, 5});
        vecs.push_back('{1, 4, 1,  4, 1, 0, 5, 15, 5});
        vecs.push_back('{0, 0, 1,  0, 0, 0, 5, 0, 0});
        vecs.push_back('{1, 1, 0,  1, 0, 0, 5, 0, 0});

        RSTn = 1'b0; en_a = 1'b0; det_a = 1'b0; en_b = 1'b0; det_b = 1'b0;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        check_a("reset", 0, 0, 0, 0, 0, 0);

        // Directed vector table
        foreach (vecs[i]) begin
            repeat (vecs[i].idle) tick_a(vecs[i].en != 0, 1'b0);
            if (vecs[i].strobe != 0) tick_a(vecs[i].en != 0, 1'b1);
            check_a($sformatf("vec%0d", i), vecs[i].st, vecs[i].lk, vecs[i].lost,
                    longint'(vecs[i].per), vecs[i].dc, vecs[i].mc);
        end
        tick_a(1'b0, 1'b0);

        // Short counter: strobes 20 apart time out MEASURE and never lock
        tick_b(1'b1, 1'b0);
        check("b_search.state", longint'(state_b), 1);
        for (int r = 0; r < 3; r++) begin
            tick_b(1'b1, 1'b1);
            check("b_strobe.state", longint'(state_b), 2);
            check("b_strobe.det_count", longint'(dc_b), longint'(r + 1));
            repeat (14) tick_b(1'b1, 1'b0);
            check("b_s14.state", longint'(state_b), 2);
            tick_b(1'b1, 1'b0);
            check("b_timeout.state", longint'(state_b), 1);
            check("b_timeout.locked", longint'(locked_b), 0);
            check("b_timeout.period", longint'(period_b), 0);
            repeat (4) tick_b(1'b1, 1'b0);
        end
        tick_b(1'b1, 1'b1);
        repeat (3) tick_b(1'b1, 1'b0);
        check("b_run.state", longint'(state_b), 2);
        tick_b(1'b0, 1'b0);
        check("b_disable.state", longint'(state_b), 0);
        check("b_disable.det_count", longint'(dc_b), 0);
        check("b_disable.locked", longint'(locked_b), 0);

        // Randomized strobe trains against the reference model
        RSTn = 1'b0; en_a = 1'b0; det_a = 1'b0; en_b = 1'b0; det_b = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        begin
            int p, ph;
            bit e, d;
            ph = 0;
            for (int seg = 0; seg < 20; seg++) begin
                p = int'($urandom_range(12, 3));
                for (int k = 0; k < 100; k++) begin
                    e = ($urandom_range(99, 0) != 0);
                    d = 1'b0;
                    ph++;
                    if (ph >= p) begin
                        ph = 0;
                        d  = ($urandom_range(9, 0) != 0);
                    end else if ($urandom_range(29, 0) == 0) begin
                        d = 1'b1;
                    end
                    rstep(e, d);
                end
            end
        end

        // Asynchronous reset between clock edges
        tick_a(1'b0, 1'b0);
        tick_a(1'b1, 1'b0);
        tick_a(1'b1, 1'b1);
        repeat (4) tick_a(1'b1, 1'b0);
        tick_a(1'b1, 1'b1);
        check_a("pre_rst", 3, 0, 0, 5, 2, 0);
        #2;
        RSTn = 1'b0;
        #1;
        check_a("async_rst", 0, 0, 0, 0, 0, 0);
        check("async_rst.b_state", longint'(state_b), 0);
        @(negedge CLK);
        RSTn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
